ram_arbiter: RTL

- Shares one synchronous single-port RAM between two requesters: the 6502 bus (read/write) and the VDP text fetch (read-only).
- Sits between address_decode/cpu and the RAM macro, on the clock_50 domain.
- Video has priority; a starvation counter guarantees the CPU a slot within a bounded number of cycles.
- Handshakes are level request / one-cycle ack, with pipelined issue, so both requesters can be served in alternate cycles.

---
 rtl/computer_pkg.sv | 13 +
 rtl/ram_arbiter_if.sv | 32 +++
 rtl/arb_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared types for the RAM arbiter slice: access owner tags and default bus widths.
package computer_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// CPU, video and RAM-macro signals of the arbiter; slave = arbiter side, master = requesters/RAM.
interface ram_arbiter_if
  import computer_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_dbo;
  logic          cpu_ack;
  logic [DW-1:0] cpu_dbi;
  logic          vid_req;
  logic [AW-1:0] vid_adr;
  logic          vid_ack;
  logic [DW-1:0] vid_q;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_dbo, vid_req, vid_adr, ram_q,
    output cpu_ack, cpu_dbi, vid_ack, vid_q, ram_adr, ram_d, ram_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_dbo, vid_req, vid_adr, ram_q,
    input  cpu_ack, cpu_dbi, vid_ack, vid_q, ram_adr, ram_d, ram_we
  );
endinterface

// File: rtl/arb_pick.sv
// Combinational grant decision: video first, CPU forced once it has lost STARVE_MAX times in a row.
module arb_pick
  import computer_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic       cpu_elig_i,
  input  logic       vid_elig_i,
  input  logic       cpu_req_i,
  input  logic [3:0] starve_cnt_i,
  output owner_t     grant_o,
  output logic [3:0] starve_cnt_o
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  always_comb begin
    grant_o      = OWN_NONE;
    starve_cnt_o = starve_cnt_i;
    if (cpu_elig_i && vid_elig_i)
      grant_o = (starve_cnt_i == SMAX) ? OWN_CPU : OWN_VID;
    else if (cpu_elig_i)
      grant_o = OWN_CPU;
    else if (vid_elig_i)
      grant_o = OWN_VID;

    // Only a loss while actually eligible counts as starvation.
    if (!cpu_req_i || grant_o == OWN_CPU)
      starve_cnt_o = 4'd0;
    else if (cpu_elig_i && grant_o == OWN_VID)
      starve_cnt_o = (starve_cnt_i >= SMAX) ? SMAX : starve_cnt_i + 4'd1;
  end
endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: grant, RAM sample, capture+ack.
module ram_arbiter
  import computer_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 3
) (
  input logic           clock_50,
  input logic           res,
  ram_arbiter_if.slave  bus
);
  localparam int STAGES = 2;

  // vld_q[0]=S1, vld_q[1]=S2, vld_q[2]=ack cycle
  logic [STAGES:0] vld_q;
  owner_t          own_q [STAGES+1];
  logic [1:0]      we_q;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic [AW-1:0]   ram_adr_q;
  logic [DW-1:0]   ram_d_q, cpu_dbi_q, vid_q_q;
  logic            ram_we_q;
  logic            cpu_busy, vid_busy;
  owner_t          grant;

  assign cpu_busy = (vld_q[0] && own_q[0] == OWN_CPU) || (vld_q[1] && own_q[1] == OWN_CPU);
  assign vid_busy = (vld_q[0] && own_q[0] == OWN_VID) || (vld_q[1] && own_q[1] == OWN_VID);

  arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .cpu_elig_i   (bus.cpu_req && !cpu_busy),
    .vid_elig_i   (bus.vid_req && !vid_busy),
    .cpu_req_i    (bus.cpu_req),
    .starve_cnt_i (starve_cnt_q),
    .grant_o      (grant),
    .starve_cnt_o (starve_cnt_d)
  );

  always_ff @(posedge clock_50 or negedge res) begin
    if (!res) begin
      vld_q        <= '0;
      own_q[0]     <= OWN_NONE;
      own_q[1]     <= OWN_NONE;
      own_q[2]     <= OWN_NONE;
      we_q         <= '0;
      starve_cnt_q <= '0;
      ram_adr_q    <= '0;
      ram_d_q      <= '0;
      ram_we_q     <= 1'b0;
      cpu_dbi_q    <= '0;
      vid_q_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      vld_q        <= {vld_q[STAGES-1:0], grant != OWN_NONE};
      own_q[0]     <= grant;
      own_q[1]     <= own_q[0];
      own_q[2]     <= own_q[1];
      we_q         <= {we_q[0], grant == OWN_CPU && bus.cpu_we};
      ram_we_q     <= grant == OWN_CPU && bus.cpu_we;
      if (grant == OWN_CPU) begin
        ram_adr_q <= bus.cpu_adr;
        ram_d_q   <= bus.cpu_dbo;
      end else if (grant == OWN_VID) begin
        ram_adr_q <= bus.vid_adr;
      end
      // ram_q reflects the address sampled one edge earlier, i.e. the S2 access.
      if (vld_q[1] && !we_q[1]) begin
        if (own_q[1] == OWN_CPU)
          cpu_dbi_q <= bus.ram_q;
        else if (own_q[1] == OWN_VID)
          vid_q_q <= bus.ram_q;
      end
    end
  end

  assign bus.cpu_ack = vld_q[STAGES] && own_q[STAGES] == OWN_CPU;
  assign bus.vid_ack = vld_q[STAGES] && own_q[STAGES] == OWN_VID;
  assign bus.cpu_dbi = cpu_dbi_q;
  assign bus.vid_q   = vid_q_q;
  assign bus.ram_adr = ram_adr_q;
  assign bus.ram_d   = ram_d_q;
  assign bus.ram_we  = ram_we_q;

endmodule
